// File: rtl/ram_resp_dcache_pkg.sv
// Shared types and helpers for the data-cache RAM responder.
package ram_resp_dcache_pkg;

    // Wide enough for LATENCY-1 (max 14) plus up to 3 jitter cycles.
    localparam int CNT_W = 5;

    typedef enum logic {
        DIR_READ  = 1'b0,
        DIR_WRITE = 1'b1
    } dir_t;

    // Number of WAIT cycles to spend before RESP for a transaction.
    function automatic logic [CNT_W-1:0] wait_count(input int latency, input logic [1:0] jitter);
        return CNT_W'(latency - 1) + CNT_W'(jitter);
    endfunction

endpackage

// File: rtl/ram_resp_dcache_lfsr.sv
// 8-bit Fibonacci LFSR supplying per-transaction response jitter.
// Only compiled when RAM_RESP_JITTER_EN is defined.
`include "sysconfig.v"

`ifdef RAM_RESP_JITTER_EN
module ram_resp_lfsr (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] lfsr
);
    logic [7:0] lfsr_reg;
    logic       feedback;

    assign feedback = ^(lfsr_reg & `RAM_RESP_LFSR_TAPS);

    // Free-running shift every cycle, restarting from the seed on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_reg <= `RAM_RESP_LFSR_SEED;
        else     lfsr_reg <= {lfsr_reg[6:0], feedback};
    end

    assign lfsr = lfsr_reg;
endmodule
`endif

// File: rtl/sysconfig.v
// System-wide bus widths and LFSR constants shared by the data-cache RAM responder.
`ifndef SYSCONFIG_V
`define SYSCONFIG_V

`define NPC_ADDR_BUS        31:0
`define XLEN_BUS            63:0

// Fibonacci LFSR for response jitter: x^8 + x^6 + x^5 + x^4 + 1 (taps on bits 7,5,4,3)
`define RAM_RESP_LFSR_SEED  8'hA5
`define RAM_RESP_LFSR_TAPS  8'hB8

`endif

// File: rtl/ram_resp_dcache.sv
// Data-cache RAM responder: 64-bit word storage answering one read or write
// at a time after a fixed latency (IDLE -> WAIT -> RESP -> IDLE).
// Optional feature macro: RAM_RESP_JITTER_EN adds 0..3 random WAIT cycles.
`include "sysconfig.v"

module ram_resp_dcache
    import ram_resp_dcache_pkg::*;
#(
    parameter int LATENCY   = 2,
    parameter int MEM_WORDS = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [`NPC_ADDR_BUS] ram_raddr_dcache_i,
    input  logic                 ram_raddr_valid_dcache_i,
    input  logic [7:0]           ram_rmask_dcache_i,
    output logic                 ram_rdata_ready_dcache_o,
    output logic [`XLEN_BUS]     ram_rdata_dcache_o,
    input  logic [`NPC_ADDR_BUS] ram_waddr_dcache_i,
    input  logic                 ram_waddr_valid_dcache_i,
    input  logic [7:0]           ram_wmask_dcache_i,
    input  logic [`XLEN_BUS]     ram_wdata_dcache_i,
    output logic                 ram_wdata_ready_dcache_o,
    output logic                 busy_o
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]           state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [`NPC_ADDR_BUS] addr_reg, addr_next;
    logic [7:0]           mask_reg, mask_next;
    logic [`XLEN_BUS]     wdata_reg, wdata_next;
    dir_t                 dir_reg, dir_next;
    logic [`XLEN_BUS]     rdata_reg;

    logic [`XLEN_BUS]     mem [0:MEM_WORDS-1];

    logic [1:0]           jitter;
    logic                 valid_held;
    logic                 load_rdata;
    logic                 rd_in_range, wr_in_range;
    logic [IDX_W-1:0]     rd_idx, wr_idx;
    logic                 commit;
    logic [7:0]           byte_we;
    logic                 unused_addr_bits;

`ifdef RAM_RESP_JITTER_EN
    logic [7:0] lfsr;
    logic       unused_lfsr_bits;

    ram_resp_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );
    assign jitter           = lfsr[1:0];
    assign unused_lfsr_bits = ^lfsr[7:2];
`else
    assign jitter = 2'b00;
`endif

    // The valid that keeps the in-flight transaction alive
    assign valid_held = (dir_reg == DIR_WRITE) ? ram_waddr_valid_dcache_i : ram_raddr_valid_dcache_i;

    // State, counter and latched request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            mask_reg  <= '0;
            wdata_reg <= '0;
            dir_reg   <= DIR_READ;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            mask_reg  <= mask_next;
            wdata_reg <= wdata_next;
            dir_reg   <= dir_next;
        end
    end

    // Next-state logic: writes win over reads when both are offered in IDLE
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        mask_next  = mask_reg;
        wdata_next = wdata_reg;
        dir_next   = dir_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ram_waddr_valid_dcache_i) begin
                    dir_next   = DIR_WRITE;
                    addr_next  = ram_waddr_dcache_i;
                    mask_next  = ram_wmask_dcache_i;
                    wdata_next = ram_wdata_dcache_i;
                    cnt_next   = wait_count(LATENCY, jitter);
                    state_next = (cnt_next == '0) ? ST_RESP : ST_WAIT;
                end else if (ram_raddr_valid_dcache_i) begin
                    dir_next   = DIR_READ;
                    addr_next  = ram_raddr_dcache_i;
                    mask_next  = ram_rmask_dcache_i;
                    cnt_next   = wait_count(LATENCY, jitter);
                    state_next = (cnt_next == '0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!valid_held) begin
                    // Requester withdrew: abandon without commit or ready
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Read data is fetched on the edge that enters RESP, so it is valid during the ready cycle
    assign load_rdata  = (state_next == ST_RESP) && (state_reg != ST_RESP) && (dir_next == DIR_READ);
    assign rd_idx      = addr_next[IDX_W+2:3];
    assign rd_in_range = ((addr_next >> (IDX_W + 3)) == '0);

    // Registered read data; holds between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             rdata_reg <= '0;
        else if (load_rdata) rdata_reg <= rd_in_range ? mem[rd_idx] : '0;
    end

    // Writes land at the end of the RESP cycle; out-of-range writes are dropped
    assign wr_idx      = addr_reg[IDX_W+2:3];
    assign wr_in_range = ((addr_reg >> (IDX_W + 3)) == '0);
    assign commit      = (state_reg == ST_RESP) && (dir_reg == DIR_WRITE) && wr_in_range;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign byte_we[gi] = commit & mask_reg[gi];
        end
    endgenerate

    // Byte-lane storage update; storage is deliberately not reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (byte_we[b]) mem[wr_idx][8*b +: 8] <= wdata_reg[8*b +: 8];
        end
    end

    assign unused_addr_bits = ^addr_reg[2:0];

    assign ram_rdata_ready_dcache_o = (state_reg == ST_RESP) && (dir_reg == DIR_READ);
    assign ram_wdata_ready_dcache_o = (state_reg == ST_RESP) && (dir_reg == DIR_WRITE);
    assign ram_rdata_dcache_o       = rdata_reg;
    assign busy_o                   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ram_resp_dcache.sv
// Self-checking bench for ram_resp_dcache: directed vector table, hand-built
// multi-cycle sequences, then randomized traffic against a word-array model.
module tb_ram_resp_dcache;
    localparam int LAT        = 2;
    localparam int WORDS      = 1024;
    localparam int RAND_WORDS = 64;
    localparam int NVEC       = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] raddr, waddr;
    logic        rvalid, wvalid;
    logic [7:0]  rmask, wmask;
    logic [63:0] wdata;
    logic        rready, wready, busy;
    logic [63:0] rdata;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
        logic [63:0] exp;
    } vec_t;

    vec_t        tbl [NVEC];
    logic [63:0] model [RAND_WORDS];

    always #5 clk = ~clk;

    ram_resp_dcache #(.LATENCY(LAT), .MEM_WORDS(WORDS)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .ram_raddr_dcache_i       (raddr),
        .ram_raddr_valid_dcache_i (rvalid),
        .ram_rmask_dcache_i       (rmask),
        .ram_rdata_ready_dcache_o (rready),
        .ram_rdata_dcache_o       (rdata),
        .ram_waddr_dcache_i       (waddr),
        .ram_waddr_valid_dcache_i (wvalid),
        .ram_wmask_dcache_i       (wmask),
        .ram_wdata_dcache_i       (wdata),
        .ram_wdata_ready_dcache_o (wready),
        .busy_o                   (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_lat(input string name, input int lat, input int base);
        bit ok;
        vectors++;
`ifdef RAM_RESP_JITTER_EN
        ok = (lat >= base) && (lat <= base + 3);
`else
        ok = (lat == base);
`endif
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: latency %0d cycles, expected %0d", name, lat, base);
        end
    endtask

    // Issue one transaction, count cycles to its ready, then drop valid and return in IDLE
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [63:0] wd,
                       input logic [7:0] m, output int lat, output logic [63:0] rd, output bit stray);
        lat   = 0;
        stray = 1'b0;
        if (wr) begin
            waddr = addr; wdata = wd; wmask = m; wvalid = 1'b1;
        end else begin
            raddr = addr; rmask = m; rvalid = 1'b1;
        end
        do begin
            step();
            lat++;
            if (wr ? rready : wready) stray = 1'b1;
        end while (!(wr ? wready : rready) && lat < 40);
        rd     = rdata;
        wvalid = 1'b0;
        rvalid = 1'b0;
        step();
    endtask

    task automatic run_and_check(input string name, input bit wr, input logic [31:0] addr,
                                 input logic [63:0] wd, input logic [7:0] m, input logic [63:0] exp);
        int          lat;
        logic [63:0] rd;
        bit          stray;
        txn(wr, addr, wd, m, lat, rd, stray);
        $display("txn %s: %s addr=%h lat=%0d data=%h", name, wr ? "WR" : "RD", addr, lat, wr ? wd : rd);
        chk_lat({name, "_lat"}, lat, LAT);
        chk({name, "_stray_ready"}, 64'(stray), 64'd0);
        if (!wr) begin
            chk({name, "_rdata"}, rd, exp);
            chk({name, "_rdata_hold"}, rdata, exp);
        end
    endtask

    initial begin : main
        int          lat;
        bit          seen;
        logic [31:0] a;
        logic [63:0] d, e;
        logic [7:0]  m;
        bit          wr;

        rst = 1'b1; rvalid = 1'b0; wvalid = 1'b0;
        raddr = '0; waddr = '0; rmask = '0; wmask = '0; wdata = '0;

        tbl[0]  = '{1'b1, 32'h0000_0000, 64'h0123456789ABCDEF, 8'hFF, 64'h0};
        tbl[1]  = '{1'b1, 32'h0000_0010, 64'h1122334455667788, 8'hFF, 64'h0};
        tbl[2]  = '{1'b0, 32'h0000_0010, 64'h0,                8'hFF, 64'h1122334455667788};
        tbl[3]  = '{1'b1, 32'h0000_0010, 64'hAAAAAAAABBBBBBBB, 8'h0F, 64'h0};
        tbl[4]  = '{1'b0, 32'h0000_0010, 64'h0,                8'hFF, 64'h11223344BBBBBBBB};
        tbl[5]  = '{1'b0, 32'h0000_0017, 64'h0,                8'h01, 64'h11223344BBBBBBBB};
        tbl[6]  = '{1'b1, 32'h0000_0010, 64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0};
        tbl[7]  = '{1'b0, 32'h0000_0010, 64'h0,                8'hFF, 64'h11223344BBBBBBBB};
        tbl[8]  = '{1'b0, 32'h0000_2000, 64'h0,                8'hFF, 64'h0};
        tbl[9]  = '{1'b1, 32'h0000_2000, 64'h5555555555555555, 8'hFF, 64'h0};
        tbl[10] = '{1'b0, 32'h0000_0000, 64'h0,                8'hFF, 64'h0123456789ABCDEF};
        tbl[11] = '{1'b1, 32'h0000_0018, 64'h0,                8'hFF, 64'h0};
        tbl[12] = '{1'b1, 32'h0000_0018, 64'hFFFFFFFFFFFFFFFF, 8'hA5, 64'h0};
        tbl[13] = '{1'b0, 32'h0000_0018, 64'h0,                8'hFF, 64'hFF00FF0000FF00FF};
        tbl[14] = '{1'b1, 32'h0000_1FF8, 64'hCAFEF00D12345678, 8'hFF, 64'h0};
        tbl[15] = '{1'b0, 32'h0000_1FFF, 64'h0,                8'h80, 64'hCAFEF00D12345678};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_rready", 64'(rready), 64'd0);
        chk("reset_wready", 64'(wready), 64'd0);
        chk("reset_busy",   64'(busy),   64'd0);
        chk("reset_rdata",  rdata,       64'd0);
        step();
        rst = 1'b0;
        step();

        // Directed vector table
        for (int i = 0; i < NVEC; i++) begin
            run_and_check($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].mask, tbl[i].exp);
        end

        // Back-to-back reads: valid held, address switched on the ready cycle
        run_and_check("b2b_prep", 1'b1, 32'h08, 64'h0808080808080808, 8'hFF, 64'h0);
        raddr = 32'h00; rmask = 8'hFF; rvalid = 1'b1; lat = 0;
        do begin step(); lat++; end while (!rready && lat < 40);
        chk_lat("b2b_first_lat", lat, LAT);
        chk("b2b_first_rdata", rdata, 64'h0123456789ABCDEF);
        raddr = 32'h08; lat = 0;
        do begin step(); lat++; end while (!rready && lat < 40);
        chk_lat("b2b_gap", lat, LAT + 1);
        chk("b2b_second_rdata", rdata, 64'h0808080808080808);
        $display("txn b2b: two reads, gap=%0d", lat);
        rvalid = 1'b0;
        step();

        // Simultaneous read and write to the same word: write goes first
        waddr = 32'h20; wdata = 64'hDEAD; wmask = 8'hFF; wvalid = 1'b1;
        raddr = 32'h20; rmask = 8'hFF; rvalid = 1'b1; lat = 0;
        do begin step(); lat++; end while (!rready && !wready && lat < 40);
        chk_lat("both_wr_lat", lat, LAT);
        chk("both_wready_first", 64'(wready), 64'd1);
        chk("both_no_rready", 64'(rready), 64'd0);
        wvalid = 1'b0; lat = 0;
        do begin step(); lat++; end while (!rready && lat < 40);
        chk_lat("both_rd_lat", lat, LAT + 1);
        chk("both_rdata", rdata, 64'hDEAD);
        $display("txn both: write then read of 0x20, rdata=%h", rdata);
        rvalid = 1'b0;
        step();

        // Abort: write valid withdrawn during WAIT must not commit or respond
        waddr = 32'h10; wdata = 64'h0; wmask = 8'hFF; wvalid = 1'b1;
        step();
        wvalid = 1'b0; seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (rready || wready) seen = 1'b1;
        end
        chk("abort_no_ready", 64'(seen), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);
        $display("txn abort: write to 0x10 withdrawn");
        run_and_check("abort_read", 1'b0, 32'h10, 64'h0, 8'hFF, 64'h11223344BBBBBBBB);

        // Reset in the middle of a write's WAIT phase
        run_and_check("rst_prep", 1'b1, 32'h30, 64'h3030303030303030, 8'hFF, 64'h0);
        run_and_check("rst_prep_rd", 1'b0, 32'h30, 64'h0, 8'hFF, 64'h3030303030303030);
        waddr = 32'h30; wdata = 64'h0BAD0BAD0BAD0BAD; wmask = 8'hFF; wvalid = 1'b1;
        step();
        #3 rst = 1'b1;
        #1;
        chk("midrst_busy",   64'(busy),   64'd0);
        chk("midrst_wready", 64'(wready), 64'd0);
        chk("midrst_rdata",  rdata,       64'd0);
        wvalid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (rready || wready) seen = 1'b1;
        end
        chk("midrst_no_ready", 64'(seen), 64'd0);
        rst = 1'b0;
        step();
        $display("txn midrst: write to 0x30 interrupted by reset");
        run_and_check("midrst_read", 1'b0, 32'h30, 64'h0, 8'hFF, 64'h3030303030303030);

        // Randomized traffic against a word-array model
        for (int i = 0; i < RAND_WORDS; i++) begin
            model[i] = {$urandom, $urandom};
            run_and_check($sformatf("init%0d", i), 1'b1, 32'(i * 8), model[i], 8'hFF, 64'h0);
        end
        for (int i = 0; i < 200; i++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_2000;
            else                           a = 32'($urandom_range(0, RAND_WORDS - 1) * 8 + $urandom_range(0, 7));
            d = {$urandom, $urandom};
            m = 8'($urandom_range(0, 255));
            e = (a < WORDS * 8) ? model[a / 8] : 64'h0;
            run_and_check($sformatf("rnd%0d", i), wr, a, d, m, e);
            if (wr && a < WORDS * 8) begin
                for (int b = 0; b < 8; b++) begin
                    if (m[b]) model[a / 8][8*b +: 8] = d[8*b +: 8];
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule
